dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single data-memory port between the CPU pipeline's MEM stage and a debug/loader requester. It sits between the EX/MEM pipeline register and Data_Memory. The CPU has default priority. A starvation counter forces a debug slot and stalls the pipeline when debug has waited too long. It also counts arbitration stall cycles for the bench's stall statistics.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a pending debug request may lose to the CPU before a forced debug slot (1..15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  pipeline running; low = CPU halted, debug owns the port.
- cpu_req_i  in  1  MEM-stage access (MemRead | MemWrite).
- cpu_we_i  in  1  MEM-stage write (MemWrite).
- cpu_addr_i  in  ADDR_W  ALU result (byte address).
- cpu_wdata_i  in  DATA_W  store data.
- cpu_rdata_o  out  DATA_W  load data; combinational pass-through of mem_rdata_i.
- cpu_stall_o  out  1  CPU lost the port this cycle; freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB.
- dbg_req_i, dbg_we_i  in  1  debug request and write enable.
- dbg_addr_i  in  ADDR_W  debug address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_gnt_o  out  1  debug owns the port this cycle; the transfer completes at the next rising edge.
- dbg_rvalid_o  out  1  one-cycle pulse, the cycle after a granted debug read.
- dbg_rdata_o  out  DATA_W  registered read data, valid with dbg_rvalid_o.
- mem_en_o, mem_we_o  out  1  memory access and write strobe.
- mem_addr_o  out  ADDR_W  address to memory.
- mem_wdata_o  out  DATA_W  write data to memory.
- mem_rdata_i  in  DATA_W  combinational read data from memory.
- stall_cnt_o  out  32  count of cycles with cpu_stall_o = 1; wraps modulo 2^32.

## Operation
- States:
  - HALT: start_i = 0.
  - RUN: CPU has priority.
  - DBG_SLOT: forced debug cycle.
- starve_cnt is 4 bits.
- HALT:
  - dbg_gnt_o = dbg_req_i.
  - cpu_req_i is ignored and cpu_stall_o = 0.
  - starve_cnt is held at 0.
  - Next state is RUN when start_i = 1.
- RUN, owner selection:
  - If cpu_req_i = 1, the CPU owns the port.
  - Else if dbg_req_i = 1, debug owns the port.
  - Else the port is idle: mem_en_o = 0.
- RUN, starvation counting:
  - CPU wins while dbg_req_i = 1: starve_cnt increments.
  - Debug is granted, or dbg_req_i = 0: starve_cnt clears.
  - If starve_cnt + 1 == STARVE_LIMIT on a CPU-wins edge, next state is DBG_SLOT.
- DBG_SLOT:
  - If dbg_req_i = 1: dbg_gnt_o = 1 and cpu_stall_o = cpu_req_i.
  - If dbg_req_i = 0 (request withdrawn): CPU owns the port with no stall.
  - Always clears starve_cnt. Next state is RUN, or HALT if start_i = 0.
- start_i falling in any state gives next state HALT. An in-flight dbg_rvalid_o pulse still completes.
- Mux: mem_* follow the owner's signals. mem_we_o = owner_we & mem_en_o.
- Debug read: on an edge with dbg_gnt_o & !dbg_we_i, dbg_rdata_o <= mem_rdata_i and dbg_rvalid_o <= 1. Otherwise dbg_rvalid_o <= 0 and dbg_rdata_o holds.
- A debug write produces no dbg_rvalid_o.
- stall_cnt_o increments on each edge where cpu_stall_o = 1.

## Timing
- Reset values:
  - State HALT, starve_cnt 0.
  - dbg_rvalid_o 0, dbg_rdata_o 0, stall_cnt_o 0.
  - With start_i low: cpu_stall_o 0, and dbg_gnt_o = dbg_req_i (combinational).
- Reset asserted mid-transfer aborts immediately. A pending rvalid is dropped.
- The grant/stall/mux path is combinational from current state and inputs. There is no added latency to CPU loads.
- Debug read latency is 1 cycle: dbg_rvalid_o is high the cycle after the grant.
- Worst-case debug wait in RUN is STARVE_LIMIT cycles. The forced slot costs the CPU exactly 1 stall cycle.
- A stalled CPU request keeps its inputs stable (EX/MEM frozen) and wins the following RUN cycle.
- Back-to-back forced slots are impossible: after DBG_SLOT the counter restarts from 0.

## Test plan
- Reset with start_i = 0 and a debug write of 0x1234 to addr 0x8, then a read of addr 0x8 → dbg_gnt_o is high in both cycles; dbg_rvalid_o pulses one cycle after the read with dbg_rdata_o = 0x1234; cpu_stall_o stays 0.
- start_i = 1, cpu_req_i high continuously, dbg_req_i high from cycle 0, STARVE_LIMIT = 4 → CPU is granted in cycles 0–3; cycle 4 is DBG_SLOT with dbg_gnt_o = 1 and cpu_stall_o = 1; stall_cnt_o = 1; the pattern repeats every 5 cycles.
- RUN with cpu_req_i = 0 and dbg_req_i = 1 → immediate debug grant, no stall, starve_cnt stays 0.
- Enter DBG_SLOT, then drop dbg_req_i in that cycle → CPU is granted, cpu_stall_o = 0, stall_cnt_o unchanged, next state RUN.
- Assert rst_i asynchronously mid-cycle during a granted debug read → dbg_rvalid_o never pulses; all counters read 0; state is HALT.
- CPU store of 7 to 0x10 while debug reads 0x10 in the same cycle → the CPU write lands; a later debug read returns 7; no port contention (mem_we_o matches the owner only).

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_arbiter : shares the data-memory port between the CPU MEM stage and debug
// Revision 1.0
// ----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       stall_cnt_o
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_HALT     = 2'd0,
    S_RUN      = 2'd1,
    S_DBG_SLOT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [31:0]         stall_cnt_q;

  logic                w_cpu_own;
  logic                w_dbg_own;
  logic                w_stall;

  always_comb begin
    w_cpu_own = 1'b0;
    w_dbg_own = 1'b0;
    w_stall   = 1'b0;
    state_d   = state_q;
    starve_d  = starve_q;
    case (state_q)
      S_HALT: begin
        w_dbg_own = dbg_req_i;
        starve_d  = 4'd0;
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        w_cpu_own = cpu_req_i;
        w_dbg_own = dbg_req_i & ~cpu_req_i;
        // Debug losing to the CPU accumulates toward a forced slot.
        if (cpu_req_i && dbg_req_i) begin
          starve_d = starve_q + 4'd1;
          if (starve_q + 4'd1 == C_STARVE_LIMIT) state_d = S_DBG_SLOT;
        end else begin
          starve_d = 4'd0;
        end
      end
      S_DBG_SLOT: begin
        w_dbg_own = dbg_req_i;
        w_cpu_own = cpu_req_i & ~dbg_req_i;
        w_stall   = cpu_req_i & dbg_req_i;
        starve_d  = 4'd0;
        state_d   = S_RUN;
      end
      default: begin
        state_d  = S_HALT;
        starve_d = 4'd0;
      end
    endcase
    if (!start_i) begin
      state_d  = S_HALT;
      starve_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_HALT;
      starve_q    <= 4'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= w_dbg_own & ~dbg_we_i;
      if (w_dbg_own && !dbg_we_i) rdata_q <= mem_rdata_i;
      if (w_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign mem_en_o     = w_cpu_own | w_dbg_own;
  assign mem_addr_o   = w_dbg_own ? dbg_addr_i  : cpu_addr_i;
  assign mem_wdata_o  = w_dbg_own ? dbg_wdata_i : cpu_wdata_i;
  assign mem_we_o     = (w_dbg_own ? dbg_we_i : cpu_we_i) & mem_en_o;

  assign cpu_rdata_o  = mem_rdata_i;
  assign cpu_stall_o  = w_stall;
  assign dbg_gnt_o    = w_dbg_own;
  assign dbg_rvalid_o = rvalid_q;
  assign dbg_rdata_o  = rdata_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : randomized and directed checks of dmem_arbiter against a model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stall_cnt;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o(dbg_rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // Data memory seen by the arbiter: combinational read, write on the edge.
  logic [31:0] mem [0:63] = '{default: 32'd0};
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state.
  logic [31:0] ref_mem [0:63] = '{default: 32'd0};
  bit          m_running = 0;
  bit          m_forced  = 0;
  int          m_losses  = 0;
  bit          m_rvalid  = 0;
  logic [31:0] m_rdata   = '0;
  logic [31:0] m_stalls  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_forced = 0; m_losses = 0;
    m_rvalid = 0; m_rdata = '0; m_stalls = '0;
  endtask

  task automatic cyc(input bit st, input bit cr, input bit cw, input logic [31:0] ca,
                     input logic [31:0] cd, input bit dr, input bit dw,
                     input logic [31:0] da, input logic [31:0] dd);
    bit e_gnt, e_cpu, e_stall, e_en, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    @(negedge clk);
    start = st; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    if (!m_running) begin
      e_gnt = dr; e_cpu = 0; e_stall = 0;
    end else if (m_forced) begin
      e_gnt = dr; e_cpu = cr && !dr; e_stall = cr && dr;
    end else begin
      e_cpu = cr; e_gnt = dr && !cr; e_stall = 0;
    end
    e_en    = e_gnt || e_cpu;
    e_addr  = e_gnt ? da : ca;
    e_wdata = e_gnt ? dd : cd;
    e_we    = e_gnt ? dw : (e_cpu && cw);
    e_rd    = ref_mem[e_addr[7:2]];
    #1;
    chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e_gnt});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    if (e_en) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_rdata", cpu_rdata, e_rd);
    end
    @(posedge clk);
    #1;
    if (e_en && e_we) ref_mem[e_addr[7:2]] = e_wdata;
    m_rvalid = e_gnt && !dw;
    if (m_rvalid) m_rdata = e_rd;
    if (e_stall) m_stalls = m_stalls + 32'd1;
    if (!st) begin
      m_running = 0; m_forced = 0; m_losses = 0;
    end else if (!m_running || m_forced) begin
      m_running = 1; m_forced = 0; m_losses = 0;
    end else if (cr && dr) begin
      m_losses++;
      if (m_losses == LIMIT) begin m_forced = 1; m_losses = 0; end
    end else begin
      m_losses = 0;
    end
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_rvalid});
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("stall_cnt", stall_cnt, m_stalls);
  endtask

  function automatic logic [31:0] raddr();
    return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    logic [31:0] saved;
    int waited;
    // Reset values with the CPU halted.
    #3;
    chk("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Halted: debug write then read of 0x8, CPU request ignored.
    cyc(0, 1, 0, 32'h20, 32'h0, 1, 1, 32'h8, 32'h1234);
    cyc(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h8, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("halt_read_1234", dbg_rdata, 32'h1234);

    // Continuous contention: forced slot every LIMIT+1 cycles.
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, raddr(), $urandom, 1, 0, raddr(), 32'h0);

    // Debug alone in RUN is granted at once.
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);

    // Reach a forced slot, then withdraw the debug request in it.
    waited = 0;
    while (!m_forced && waited < 20) begin
      cyc(1, 1, 0, raddr(), 32'h0, 1, 0, raddr(), 32'h0);
      waited++;
    end
    if (!m_forced) begin
      ncmp++; nfail++;
      $error("FAIL slot_timeout observed=%0d expected=%0d", waited, LIMIT);
    end
    saved = stall_cnt;
    cyc(1, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("slot_withdraw_stalls", stall_cnt, saved);

    // Simultaneous CPU store and debug read of 0x10: the CPU wins and writes.
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    cyc(1, 1, 1, 32'h10, 32'd7, 1, 0, 32'h10, 32'h0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    chk("cpu_store_read_back", dbg_rdata, 32'd7);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
          raddr(), $urandom, $urandom_range(0, 2) != 0, 1'($urandom), raddr(), $urandom);

    // Asynchronous reset in the middle of a granted debug read.
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    #2 rst = 1'b1;
    #1;
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    @(posedge clk); #1;
    chk("arst_no_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    @(negedge clk);
    start = 1; cpu_req = 1; dbg_req = 0;
    #1;
    chk("arst_halt_ignores_cpu", {31'd0, mem_en}, 32'd0);
    chk("arst_halt_no_stall", {31'd0, cpu_stall}, 32'd0);
    start = 0; cpu_req = 0;
    @(negedge clk); rst = 1'b0;
    model_reset();

    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
          raddr(), $urandom, $urandom_range(0, 2) != 0, 1'($urandom), raddr(), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
